// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op/state encodings and the ALU sel map shared by the matrix ALU sequencer.
package alu_seq_pkg;
    typedef enum logic [2:0] {OP_TRANSPOSE, OP_ADD, OP_SUB, OP_MUL, OP_SCALE, OP_DET} op_e;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_C, S_LOAD_E, S_LOAD_F, S_EXEC, S_SETTLE, S_READ} state_e;
    localparam logic [5:0] SEL_E_BASE  = 6'd0;
    localparam logic [5:0] SEL_F_BASE  = 6'd9;
    localparam logic [5:0] SEL_G_BASE  = 6'd18;
    localparam logic [5:0] SEL_DET     = 6'd27;
    localparam logic [5:0] SEL_OP_BASE = 6'd28;
    localparam logic [5:0] SEL_C       = 6'd40;
    function automatic logic needs_f(op_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL};
    endfunction
endpackage

// File: rtl/alu_matrix_sequencer.sv
// alu_matrix_sequencer: loads c/E/F into the 3x3 matrix ALU, issues the op, streams G or det out.
module alu_matrix_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW = 32,
  parameter logic [5:0] PARK_SEL = 6'd63,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [5:0]    alu_sel,
  output logic [DW-1:0] alu_ele_in,
  input  logic [DW-1:0] alu_ele_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          err
);
  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [3:0]    idx_q, idx_d;
  logic [5:0]    alu_sel_q, alu_sel_d;
  logic [DW-1:0] alu_ele_in_q, alu_ele_in_d;
  logic          err_q, err_d;
  logic          in_hs, rd_last, tmo_hit;
  assign cmd_ready  = state_q == S_IDLE;
  assign in_ready   = state_q inside {S_LOAD_C, S_LOAD_E, S_LOAD_F};
  assign in_hs      = in_valid && in_ready;
  assign out_valid  = state_q == S_READ;
  assign rd_last    = op_q == OP_DET || idx_q == 4'd8;
  assign out_last   = out_valid && rd_last;
  assign out_data   = alu_ele_out;
  assign busy       = !cmd_ready;
  assign err        = err_q;
  assign alu_sel    = alu_sel_q;
  assign alu_ele_in = alu_ele_in_q;
`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo_hit = in_ready && !in_hs && tmo_q == TW'(TIMEOUT_CYC - 1);
  always_comb tmo_d = (in_ready && !in_hs && !tmo_hit) ? tmo_q + 1'b1 : '0;
  always_ff @(posedge clk) tmo_q <= reset ? '0 : tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    alu_sel_d    = PARK_SEL;
    alu_ele_in_d = alu_ele_in_q;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        if (cmd_op > 3'd5) err_d = 1'b1;
        else begin
          op_d    = op_e'(cmd_op);
          idx_d   = '0;
          state_d = cmd_op == OP_SCALE ? S_LOAD_C : S_LOAD_E;
        end
      end
      S_LOAD_C, S_LOAD_E, S_LOAD_F: if (tmo_hit) begin
        state_d = S_IDLE;
        idx_d   = '0;
        err_d   = 1'b1;
      end else if (in_valid) begin
        alu_ele_in_d = in_data;
        alu_sel_d    = state_q == S_LOAD_C ? SEL_C :
                       state_q == S_LOAD_E ? SEL_E_BASE + 6'(idx_q) : SEL_F_BASE + 6'(idx_q);
        idx_d        = (state_q == S_LOAD_C || idx_q == 4'd8) ? '0 : idx_q + 4'd1;
        if (state_q == S_LOAD_C) state_d = S_LOAD_E;
        else if (idx_q == 4'd8) state_d = (state_q == S_LOAD_E && needs_f(op_q)) ? S_LOAD_F : S_EXEC;
      end
      S_EXEC: begin
        alu_sel_d = SEL_OP_BASE + 6'(op_q);
        state_d   = S_SETTLE;
      end
      S_SETTLE: begin
        alu_sel_d = op_q == OP_DET ? SEL_DET : SEL_G_BASE;
        state_d   = S_READ;
      end
      S_READ: begin
        alu_sel_d = alu_sel_q;
        if (out_ready && rd_last) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          alu_sel_d = PARK_SEL;
        end else if (out_ready) begin
          idx_d     = idx_q + 4'd1;
          alu_sel_d = SEL_G_BASE + 6'(idx_q) + 6'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= OP_TRANSPOSE;
      idx_q        <= '0;
      alu_sel_q    <= PARK_SEL;
      alu_ele_in_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      alu_sel_q    <= alu_sel_d;
      alu_ele_in_q <= alu_ele_in_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_matrix_sequencer.sv
// tb_alu_matrix_sequencer: directed and random command runs against a behavioural 3x3 matrix ALU.
module tb_alu_matrix_sequencer;
  typedef logic [31:0] mat_t [9];
  localparam logic [5:0] PARK = 6'd63;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, in_valid = 0, in_ready, out_valid, out_ready = 0, out_last, busy, err;
  logic [2:0] cmd_op = 0;
  logic [31:0] in_data = 0, alu_ele_in, alu_ele_out, out_data;
  logic [5:0] alu_sel;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] tc;
  mat_t te, tf, ae, af, ag;
  logic [31:0] ac, adet;

  alu_matrix_sequencer #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .alu_sel(alu_sel),
    .alu_ele_in(alu_ele_in), .alu_ele_out(alu_ele_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic mat_t calc(logic [2:0] op, logic [31:0] c, mat_t e, mat_t f);
    mat_t g;
    logic [31:0] d;
    d = e[0] * (e[4] * e[8] - e[5] * e[7]) - e[1] * (e[3] * e[8] - e[5] * e[6]) + e[2] * (e[3] * e[7] - e[4] * e[6]);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        case (op)
          3'd0: g[r*3+k] = e[k*3+r];
          3'd1: g[r*3+k] = e[r*3+k] + f[r*3+k];
          3'd2: g[r*3+k] = e[r*3+k] - f[r*3+k];
          3'd3: g[r*3+k] = e[r*3] * f[k] + e[r*3+1] * f[3+k] + e[r*3+2] * f[6+k];
          3'd4: g[r*3+k] = c * e[r*3+k];
          default: g[r*3+k] = (r == 0 && k == 0) ? d : 32'd0;
        endcase
    return g;
  endfunction

  always @(posedge clk) begin
    mat_t t;
    int s;
    s = int'(alu_sel);
    if (s < 9) ae[s] <= alu_ele_in;
    else if (s < 18) af[s-9] <= alu_ele_in;
    else if (s == 40) ac <= alu_ele_in;
    else if (s >= 28 && s <= 33) begin
      t = calc(3'(s - 28), ac, ae, af);
      if (s == 33) adet <= t[0];
      else ag <= t;
    end
  end
  always_comb begin
    int s;
    s = int'(alu_sel);
    alu_ele_out = (s >= 18 && s <= 26) ? ag[s-18] : (s == 27) ? adet : 32'd0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input int gap_pct, input int bp_pct, input int stall_at, input int abort_at);
    logic [31:0] words[$];
    logic [5:0] wsel[$];
    logic [5:0] exp_sel;
    mat_t exp;
    int nres, k, budget, t0, stall;
    exp = calc(op, tc, te, tf);
    nres = (op == 3'd5) ? 1 : 9;
    if (op == 3'd4) begin words.push_back(tc); wsel.push_back(6'd40); end
    for (int i = 0; i < 9; i++) begin words.push_back(te[i]); wsel.push_back(6'(i)); end
    if (op inside {3'd1, 3'd2, 3'd3})
      for (int i = 0; i < 9; i++) begin words.push_back(tf[i]); wsel.push_back(6'(9 + i)); end
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; t0 = cyc;
    @(negedge clk);
    cmd_valid = 0;
    chk("busy", busy, 1);
    exp_sel = PARK; k = 0; budget = 0;
    while (k < words.size() && k != abort_at && budget < 500) begin
      chk("load_sel", alu_sel, exp_sel);
      chk("in_ready", in_ready, 1);
      in_valid = $urandom_range(99) >= gap_pct;
      in_data = words[k];
      exp_sel = in_valid ? wsel[k] : PARK;
      @(negedge clk);
      if (in_valid) k++;
      budget++;
    end
    in_valid = 0;
    chk("load_budget", budget < 500, 1);
    if (k == abort_at) return;
    chk("exec_sel", alu_sel, exp_sel);
    chk("exec_in_ready", in_ready, 0);
    cmd_valid = 1; cmd_op = 3'($urandom_range(7)); in_valid = 1; in_data = $urandom;
    @(negedge clk);
    chk("op_sel", alu_sel, 28 + op);
    chk("settle_ov", out_valid, 0);
    chk("settle_err", err, 0);
    @(negedge clk);
    if (gap_pct == 0) chk("latency", cyc - t0, words.size() + 3);
    k = 0; budget = 0; stall = 0;
    while (k < nres && budget < 500) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp[k]);
      chk("out_last", out_last, k == nres - 1);
      chk("read_sel", alu_sel, op == 3'd5 ? 27 : 18 + k);
      chk("read_err", err, 0);
      if (k == stall_at && stall < 5) begin out_ready = 0; stall++; end
      else out_ready = $urandom_range(99) >= bp_pct;
      in_valid = 1'($urandom_range(1)); in_data = $urandom;
      @(negedge clk);
      if (out_ready) k++;
      budget++;
    end
    out_ready = 0; in_valid = 0; cmd_valid = 0;
    chk("read_budget", budget < 500, 1);
    chk("done_busy", busy, 0);
    chk("done_ov", out_valid, 0);
    chk("done_sel", alu_sel, PARK);
  endtask

  task automatic rand_mats();
    tc = $urandom;
    for (int i = 0; i < 9; i++) begin te[i] = $urandom; tf[i] = $urandom; end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sel", alu_sel, PARK);
    chk("rst_ele", alu_ele_in, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin te[i] = i + 1; tf[i] = 9; end
    run_op(3'd1, 0, 0, -1, -1);
    te = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 9; i++) tf[i] = i + 1;
    run_op(3'd3, 0, 0, -1, -1);
    tc = 3;
    for (int i = 0; i < 9; i++) te[i] = i + 1;
    run_op(3'd4, 0, 0, -1, -1);
    te = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
    run_op(3'd5, 0, 0, -1, -1);
    for (int i = 0; i < 9; i++) te[i] = i + 1;
    run_op(3'd0, 0, 0, -1, -1);
    rand_mats();
    run_op(3'd2, 40, 0, 4, -1);
    for (int op = 6; op < 8; op++) begin
      cmd_valid = 1; cmd_op = 3'(op);
      @(negedge clk);
      cmd_valid = 0;
      chk("illegal_err", err, 1);
      chk("illegal_busy", busy, 0);
      chk("illegal_sel", alu_sel, PARK);
      @(negedge clk);
      chk("illegal_err_pulse", err, 0);
    end
    rand_mats();
    run_op(3'd1, 0, 0, -1, 12);
    reset = 1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_sel", alu_sel, PARK);
    chk("midrst_ov", out_valid, 0);
    reset = 0;
    @(negedge clk);
`ifdef ALU_SEQ_TIMEOUT_EN
    begin
      int n;
      rand_mats();
      run_op(3'd0, 0, 0, -1, 4);
      n = 0;
      while (!err && n < 40) begin @(negedge clk); n++; end
      chk("tmo_cycles", n, 16);
      chk("tmo_busy", busy, 0);
      chk("tmo_sel", alu_sel, PARK);
      @(negedge clk);
      chk("tmo_err_pulse", err, 0);
    end
`endif
    for (int t = 0; t < 40; t++) begin
      rand_mats();
      run_op(3'($urandom_range(5)), 25, 30, -1, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
